// File: rtl/byte_serializer.sv
// byte_serializer: WIDTH-bit word to async serial frame.
// start, LSB-first data, optional even parity, stop.
module byte_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int DW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW =
    (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST =
    DW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_n;
  logic [DW-1:0]    div_q, div_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             done_q, done_n;
  logic             rdy_q, rdy_n;
  logic             busy_q;
  logic             bit_end;

  assign bit_end = (div_q == DIV_LAST);

  // next-state, divider, shifter and line level
  always_comb begin
    state_n = state_q;
    div_n   = bit_end ? '0 : div_q + DW'(1);
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    par_n   = par_q;
    tx_n    = tx_q;
    rdy_n   = rdy_q;
    done_n  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        div_n = '0;
        tx_n  = 1'b1;
        if (enable && rdy_q) begin
          state_n = S_START;
          sh_n    = data;
          par_n   = ^data;
          cnt_n   = '0;
          tx_n    = 1'b0;
          rdy_n   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n = S_DATA;
          tx_n    = sh_q[0];
          sh_n    = sh_q >> 1;
          cnt_n   = CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (cnt_q == CNT_LAST) begin
            if (PARITY_EN != 0) begin
              state_n = S_PARITY;
              tx_n    = par_q;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            tx_n  = sh_q[0];
            sh_n  = sh_q >> 1;
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_n = S_STOP;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          rdy_n   = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        div_n   = '0;
        cnt_n   = '0;
        tx_n    = 1'b1;
        rdy_n   = 1'b1;
      end
    endcase
  end

  // state and registered outputs; reset forces idle line
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
      rdy_q   <= rdy_n;
      busy_q  <= ~rdy_n;
    end
  end

  assign tx    = tx_q;
  assign done  = done_q;
  assign ready = rdy_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed frames on three
// parameter sets (plain, parity, one clock per bit).
module tb_byte_serializer;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       en  [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       bsy [3];
  logic       txl [3];
  logic       dn  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  byte_serializer #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)
  ) u0 (
    .clock(clock), .rst(rst),
    .data(dat[0]), .enable(en[0]),
    .ready(rdy[0]), .busy(bsy[0]),
    .tx(txl[0]), .done(dn[0])
  );

  byte_serializer #(
    .WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)
  ) u1 (
    .clock(clock), .rst(rst),
    .data(dat[1]), .enable(en[1]),
    .ready(rdy[1]), .busy(bsy[1]),
    .tx(txl[1]), .done(dn[1])
  );

  byte_serializer #(
    .WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0)
  ) u2 (
    .clock(clock), .rst(rst),
    .data(dat[2]), .enable(en[2]),
    .ready(rdy[2]), .busy(bsy[2]),
    .tx(txl[2]), .done(dn[2])
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic lvl(
    input logic [7:0] d,
    input bit         pe,
    input int         s
  );
    if (s == 0) return 1'b0;
    if (s <= 8) return d[s-1];
    if (pe && s == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic idle_chk(
    input int    k,
    input string tag
  );
    check({tag, ".tx"},   32'(txl[k]), 32'd1);
    check({tag, ".rdy"},  32'(rdy[k]), 32'd1);
    check({tag, ".busy"}, 32'(bsy[k]), 32'd0);
    check({tag, ".done"}, 32'(dn[k]),  32'd0);
  endtask

  task automatic start(
    input int         k,
    input logic [7:0] d,
    input string      tag
  );
    check({tag, ".rdy_pre"}, 32'(rdy[k]), 32'd1);
    dat[k] = d;
    en[k]  = 1'b1;
    @(negedge clock);
    en[k]  = 1'b0;
  endtask

  // entered at the negedge right after the accept edge
  task automatic frame(
    input int         k,
    input logic [7:0] d,
    input int         cpb,
    input bit         pe,
    input int         exp_par,
    input int         inj,
    input string      tag
  );
    int n;
    n = (pe ? 11 : 10) * cpb;
    for (int c = 0; c <= n; c++) begin
      if (c > 0) @(negedge clock);
      if (c < n) begin
        check({tag, ".tx"}, 32'(txl[k]),
              32'(lvl(d, pe, c / cpb)));
        check({tag, ".rdy"},  32'(rdy[k]), 32'd0);
        check({tag, ".busy"}, 32'(bsy[k]), 32'd1);
        check({tag, ".done"}, 32'(dn[k]),  32'd0);
        if (pe && c == 9 * cpb)
          check({tag, ".par"}, 32'(txl[k]),
                32'(exp_par));
      end else begin
        check({tag, ".end_tx"},   32'(txl[k]), 32'd1);
        check({tag, ".end_done"}, 32'(dn[k]),  32'd1);
        check({tag, ".end_rdy"},  32'(rdy[k]), 32'd1);
        check({tag, ".end_busy"}, 32'(bsy[k]), 32'd0);
      end
      if (inj >= 0 && c == inj) begin
        dat[k] = 8'hFF;
        en[k]  = 1'b1;
      end
      if (inj >= 0 && c == inj + 1) en[k] = 1'b0;
    end
  endtask

  task automatic idle_for(
    input int    k,
    input int    cyc,
    input string tag
  );
    for (int i = 0; i < cyc; i++) begin
      @(negedge clock);
      idle_chk(k, tag);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      dat[k] = 8'h00;
    end

    #3 rst = 1'b0;
    #1;
    idle_chk(0, "rst0");
    idle_chk(1, "rst1");
    idle_chk(2, "rst2");
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);

    start(0, 8'hA5, "a5");
    frame(0, 8'hA5, 4, 1'b0, -1, -1, "a5");
    idle_for(0, 3, "a5_idle");

    start(1, 8'h07, "p07");
    frame(1, 8'h07, 4, 1'b1, 1, -1, "p07");
    idle_for(1, 2, "p07_idle");
    start(1, 8'hA5, "pa5");
    frame(1, 8'hA5, 4, 1'b1, 0, -1, "pa5");
    idle_for(1, 2, "pa5_idle");

    start(0, 8'h3C, "ign");
    frame(0, 8'h3C, 4, 1'b0, -1, 10, "ign");
    idle_for(0, 50, "ign_none");

    dat[0] = 8'h55;
    en[0]  = 1'b1;
    @(negedge clock);
    dat[0] = 8'hAA;
    frame(0, 8'h55, 4, 1'b0, -1, -1, "b2b1");
    @(negedge clock);
    en[0] = 1'b0;
    frame(0, 8'hAA, 4, 1'b0, -1, -1, "b2b2");
    idle_for(0, 5, "b2b_idle");

    start(0, 8'hA5, "mrst");
    repeat (17) @(negedge clock);
    check("mrst.bit3", 32'(txl[0]), 32'd0);
    check("mrst.busy", 32'(bsy[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    idle_chk(0, "mrst_now");
    @(negedge clock);
    rst = 1'b1;
    idle_for(0, 20, "mrst_after");

    start(2, 8'h81, "c1");
    frame(2, 8'h81, 1, 1'b0, -1, -1, "c1");
    idle_for(2, 3, "c1_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Serial transmit counterpart to the team's parallel-load register: accepts a WIDTH-bit word via a data/enable handshake and shifts it out on a single-wire asynchronous serial line.
- Frame format: start bit, WIDTH data bits LSB-first, optional even-parity bit, stop bit.
- Sits between a byte-producing datapath and an off-chip or inter-block serial link. Paces each bit with an internal clock-cycle divider.

Parameters:
- WIDTH, 8, data word width in bits; must be >= 1.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx; must be >= 1.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clock  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- data  input  WIDTH  word to transmit; sampled only on the accept edge.
- enable  input  1  transmit request; accepted when enable=1 and ready=1 at a rising edge.
- ready  output  1  1 = idle and able to accept a word.
- busy  output  1  1 = frame in progress; always the inverse of ready.
- tx  output  1  serial line; idles high; driven from a flop (glitch-free).
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Reset (rst=0, asynchronous, immediate): tx=1, ready=1, busy=0, done=0, state IDLE. Bit counter, divider and shift register are cleared.
- Reset mid-frame aborts the frame: tx returns high without waiting for a clock edge, and the partial frame is not resumed after rst deasserts.
- States:
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or STOP after WIDTH bits, each held CLKS_PER_BIT cycles.
  - PARITY -> STOP after CLKS_PER_BIT cycles.
  - STOP -> IDLE after CLKS_PER_BIT cycles.
- Accept edge: the rising edge where enable=1 and ready=1. On that edge:
  - data is latched into the shift register;
  - tx becomes 0 (start bit);
  - ready becomes 0 and busy becomes 1.
- Data bits: bit 0 first. The shift register shifts right once per bit period, so data changes after the accept edge have no effect.
- Parity bit = XOR of all latched data bits, which gives an even total count of ones across data plus parity.
- Stop bit: tx=1 for CLKS_PER_BIT cycles.
- At the edge ending the stop bit: state becomes IDLE, ready=1, busy=0, and done=1 for exactly one cycle.
- Frame length from the accept edge to the done-assert edge is exactly (WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles.
- enable while ready=0 is ignored; there is no queuing and no error flag.
- Back-to-back frames: enable=1 during the done cycle is accepted at the next edge. The minimum idle high time between frames is therefore 1 clock beyond the stop bit.
- enable held continuously produces continuous frames with that 1-cycle gap.
- Divider counts 0..CLKS_PER_BIT-1 and is cleared at every bit boundary. CLKS_PER_BIT=1 must work, giving one cycle per bit.
- Counter widths: $clog2(CLKS_PER_BIT) and $clog2(WIDTH+1) bits, minimum 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset check: rst=0 asserted asynchronously between edges -> tx=1, ready=1, busy=0, done=0 immediately, with no clock required.
- Basic frame (WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0): data=8'hA5 with a one-cycle enable -> tx sequence, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1. done pulses exactly 40 cycles after the accept edge. ready is low for those 40 cycles.
- Parity (PARITY_EN=1):
  - data=8'h07 -> parity bit 1, done at 44 cycles.
  - data=8'hA5 -> parity bit 0.
- Ignored request and data stability: after accepting 8'h3C, pulse enable with data=8'hFF at cycle 10 -> the frame still carries 8'h3C, and no second frame follows.
- Back-to-back: enable held high with data=8'h55 then 8'hAA -> second start bit begins exactly 1 cycle after the first stop bit ends. done pulses at 40 and 81 cycles.
- Mid-frame reset and CLKS_PER_BIT=1:
  - Assert rst during data bit 3 -> tx=1 at once. After release, the line stays idle until a new enable.
  - With CLKS_PER_BIT=1, data=8'h81 gives a frame of 10 cycles.
